// File: rtl/tie_queue_pump_pkg.sv
// tie_queue_pump_pkg: shared FSM state encoding and default widths for the queue pump.
package tie_queue_pump_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_BUF_DEPTH  = 2;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/tie_pump_fifo.sv
// tie_pump_fifo: small register skid FIFO with separate occupancy count.
module tie_pump_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [DATA_WIDTH-1:0]        head_o,
  output logic [$clog2(BUF_DEPTH):0]   count_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/tie_queue_pump.sv
// tie_queue_pump: pops a burst of words from an input queue and pushes them, XOR-masked,
// into an output queue through a skid FIFO, tracking word count and checksum.
module tie_queue_pump import tie_queue_pump_pkg::*; #(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [CNT_WIDTH-1:0]  LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_WIDTH-1:0]  WORD_COUNT,
  output logic [DATA_WIDTH-1:0] CHECKSUM,
  output logic                  TIE_IPQ_PopReq,
  input  logic [DATA_WIDTH-1:0] TIE_IPQ,
  input  logic                  TIE_IPQ_Empty,
  output logic                  TIE_OPQ_PushReq,
  output logic [DATA_WIDTH-1:0] TIE_OPQ,
  input  logic                  TIE_OPQ_Full
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d, pop_cnt_q, pop_cnt_d, word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [CW-1:0] fifo_count;
  logic pop, push;
  assign pop  = TIE_IPQ_PopReq && !TIE_IPQ_Empty;
  assign push = TIE_OPQ_PushReq && !TIE_OPQ_Full;
  // Requests depend only on registered state so queue stalls never ripple combinationally.
  assign TIE_IPQ_PopReq  = (state_q == S_RUN) && (pop_cnt_q != len_q) && (fifo_count != CW'(BUF_DEPTH));
  assign TIE_OPQ_PushReq = fifo_count != '0;
  assign BUSY       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign DONE       = state_q == S_DONE;
  assign WORD_COUNT = word_count_q;
  assign CHECKSUM   = checksum_q;
  tie_pump_fifo #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .push_i (pop),
    .pop_i  (push),
    .data_i (TIE_IPQ ^ XOR_MASK),
    .head_o (TIE_OPQ),
    .count_o(fifo_count)
  );
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pop_cnt_d    = pop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, push};
    checksum_d   = push ? checksum_q ^ TIE_OPQ : checksum_q;
    case (state_q)
      S_IDLE: if (START) begin
        state_d      = S_RUN;
        len_d        = LEN;
        pop_cnt_d    = '0;
        word_count_d = '0;
        checksum_d   = '0;
      end
      S_RUN:   state_d = (pop_cnt_q == len_q) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = (fifo_count == '0) ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      pop_cnt_q    <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pop_cnt_q    <= pop_cnt_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
    end
  end
endmodule

// File: tb/tb_tie_queue_pump.sv
// tb_tie_queue_pump: directed bench with an upstream source model and downstream capture;
// a second instance with a non-zero mask runs in lockstep for the masking scenario.
module tb_tie_queue_pump;
  logic        CLK = 0, RESET = 1, START = 0, ipq_stall = 0, TIE_OPQ_Full = 0;
  logic [15:0] LEN = '0;
  logic        BUSY, DONE, PopReq, PushReq, BUSY_m, DONE_m, PopReq_m, PushReq_m, Empty;
  logic [15:0] WORD_COUNT, WORD_COUNT_m;
  logic [31:0] CHECKSUM, CHECKSUM_m, OPQ, OPQ_m, IPQ;
  logic [31:0] src [64];
  logic [31:0] cap0 [64];
  logic [31:0] cap1 [64];
  int src_len = 0, ipq_idx = 0, cap_n = 0, done_cnt = 0, req_cnt = 0;
  int checks = 0, errors = 0;
  assign Empty = ipq_stall || (ipq_idx >= src_len);
  assign IPQ   = src[ipq_idx % 64];
  always #5 CLK = ~CLK;
  tie_queue_pump dut (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN), .BUSY(BUSY), .DONE(DONE),
    .WORD_COUNT(WORD_COUNT), .CHECKSUM(CHECKSUM), .TIE_IPQ_PopReq(PopReq), .TIE_IPQ(IPQ),
    .TIE_IPQ_Empty(Empty), .TIE_OPQ_PushReq(PushReq), .TIE_OPQ(OPQ), .TIE_OPQ_Full(TIE_OPQ_Full));
  tie_queue_pump #(.XOR_MASK(32'hFFFF0000)) dut_m (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN), .BUSY(BUSY_m), .DONE(DONE_m),
    .WORD_COUNT(WORD_COUNT_m), .CHECKSUM(CHECKSUM_m), .TIE_IPQ_PopReq(PopReq_m), .TIE_IPQ(IPQ),
    .TIE_IPQ_Empty(Empty), .TIE_OPQ_PushReq(PushReq_m), .TIE_OPQ(OPQ_m), .TIE_OPQ_Full(TIE_OPQ_Full));
  always @(posedge CLK) begin
    if (PopReq && !Empty) ipq_idx <= ipq_idx + 1;
    if (PushReq && !TIE_OPQ_Full) begin
      cap0[cap_n % 64] <= OPQ;
      cap1[cap_n % 64] <= OPQ_m;
      cap_n <= cap_n + 1;
    end
    if (DONE) done_cnt <= done_cnt + 1;
    if (PopReq || PushReq) req_cnt <= req_cnt + 1;
  end
  task tick(input int n);
    repeat (n) begin @(posedge CLK); @(negedge CLK); end
  endtask
  task flush();
    src_len = ipq_idx;
  endtask
  task put(input logic [31:0] w);
    src[src_len % 64] = w;
    src_len++;
  endtask
  task start_burst(input int n);
    LEN = 16'(n);
    START = 1;
    tick(1);
    START = 0;
  endtask
  task wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick(1);
      if (DONE) ok = 1;
    end
  endtask
  task test_reset();
    tick(2);
    checks++; if ({BUSY, DONE, PopReq, PushReq, WORD_COUNT, CHECKSUM, OPQ} !== '0) begin
      errors++; $display("FAIL reset_outputs busy=%b done=%b pop=%b push=%b wc=%0d cs=%h opq=%h want all 0",
        BUSY, DONE, PopReq, PushReq, WORD_COUNT, CHECKSUM, OPQ); end
    RESET = 0;
    tick(1);
  endtask
  task test_basic();
    logic [31:0] e [4];
    int d0;
    e = '{32'h11, 32'h22, 32'h33, 32'h44};
    flush(); for (int i = 0; i < 4; i++) put(e[i]);
    d0 = done_cnt;
    start_burst(4);
    checks++; if ({BUSY, PopReq, PushReq} !== 3'b110) begin
      errors++; $display("FAIL t1_start busy/pop/push=%b want 110", {BUSY, PopReq, PushReq}); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (PushReq !== 1'b1 || OPQ !== e[i]) begin
        errors++; $display("FAIL t1_word%0d push=%b opq=%h want 1 %h", i, PushReq, OPQ, e[i]); end
    end
    tick(1);
    checks++; if (PushReq !== 1'b0) begin errors++; $display("FAIL t1_push_end got %b want 0", PushReq); end
    tick(1);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL t1_done done=%b busy=%b want 1 0", DONE, BUSY); end
    tick(1);
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL t1_after done=%b busy=%b pulses=%0d want 0 0 1", DONE, BUSY, done_cnt - d0); end
    checks++; if (WORD_COUNT !== 16'd4 || CHECKSUM !== 32'h44) begin
      errors++; $display("FAIL t1_totals wc=%0d cs=%h want 4 00000044", WORD_COUNT, CHECKSUM); end
  endtask
  task test_mask();
    int base;
    bit ok;
    flush(); put(32'h1); put(32'h2);
    base = cap_n;
    start_burst(2);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_timeout got no DONE want DONE"); end
    checks++; if (cap0[base] !== 32'h1 || cap0[base+1] !== 32'h2) begin
      errors++; $display("FAIL t2_unmasked got %h %h want 1 2", cap0[base], cap0[base+1]); end
    checks++; if (cap1[base] !== 32'hFFFF0001 || cap1[base+1] !== 32'hFFFF0002) begin
      errors++; $display("FAIL t2_masked got %h %h want ffff0001 ffff0002", cap1[base], cap1[base+1]); end
    checks++; if (CHECKSUM_m !== 32'h3 || WORD_COUNT_m !== 16'd2 || cap_n - base != 2) begin
      errors++; $display("FAIL t2_totals cs=%h wc=%0d n=%0d want 3 2 2", CHECKSUM_m, WORD_COUNT_m, cap_n - base); end
    tick(1);
  endtask
  task test_full_stall();
    int base;
    bit ok;
    flush(); for (int i = 1; i <= 6; i++) put(32'(i));
    base = cap_n;
    start_burst(6);
    tick(2);
    TIE_OPQ_Full = 1;
    tick(5);
    checks++; if ({PopReq, PushReq} !== 2'b01 || OPQ !== 32'h2 || cap_n - base != 1) begin
      errors++; $display("FAIL t3_stalled pop/push=%b opq=%h n=%0d want 01 2 1", {PopReq, PushReq}, OPQ, cap_n - base); end
    tick(5);
    TIE_OPQ_Full = 0;
    wait_done(ok);
    checks++; if (!ok || cap_n - base != 6) begin
      errors++; $display("FAIL t3_count done=%b n=%0d want 1 6", ok, cap_n - base); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap0[base+i] !== 32'(i + 1)) begin
        errors++; $display("FAIL t3_order%0d got %h want %h", i, cap0[base+i], i + 1); end
    end
    checks++; if (WORD_COUNT !== 16'd6 || CHECKSUM !== 32'h7) begin
      errors++; $display("FAIL t3_totals wc=%0d cs=%h want 6 7", WORD_COUNT, CHECKSUM); end
    tick(1);
  endtask
  task test_empty_gaps();
    int base, saved;
    bit ok;
    flush(); put(32'hA); put(32'hB); put(32'hC);
    base = cap_n;
    start_burst(3);
    for (int g = 0; g < 2; g++) begin
      tick(1);
      ipq_stall = 1;
      saved = ipq_idx;
      tick(5);
      checks++; if (PopReq !== 1'b1 || ipq_idx != saved) begin
        errors++; $display("FAIL t4_gap%0d pop=%b popped=%0d want 1 0", g, PopReq, ipq_idx - saved); end
      ipq_stall = 0;
    end
    wait_done(ok);
    checks++; if (!ok || cap_n - base != 3) begin
      errors++; $display("FAIL t4_done done=%b n=%0d want 1 3", ok, cap_n - base); end
    checks++; if (cap0[base] !== 32'hA || cap0[base+1] !== 32'hB || cap0[base+2] !== 32'hC) begin
      errors++; $display("FAIL t4_order got %h %h %h want a b c", cap0[base], cap0[base+1], cap0[base+2]); end
    checks++; if (WORD_COUNT !== 16'd3 || CHECKSUM !== 32'hD) begin
      errors++; $display("FAIL t4_totals wc=%0d cs=%h want 3 d", WORD_COUNT, CHECKSUM); end
    tick(1);
  endtask
  task test_len_zero();
    int r0, d0;
    flush(); put(32'h99);
    r0 = req_cnt; d0 = done_cnt;
    start_burst(0);
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      errors++; $display("FAIL t5_run busy=%b done=%b want 1 0", BUSY, DONE); end
    START = 1;
    tick(1);
    START = 0;
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin
      errors++; $display("FAIL t5_drain busy=%b done=%b want 1 0", BUSY, DONE); end
    tick(1);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL t5_done done=%b busy=%b want 1 0", DONE, BUSY); end
    tick(4);
    checks++; if (BUSY !== 1'b0 || done_cnt - d0 != 1 || req_cnt != r0 || WORD_COUNT !== 16'd0) begin
      errors++; $display("FAIL t5_quiet busy=%b pulses=%0d reqs=%0d wc=%0d want 0 1 0 0",
        BUSY, done_cnt - d0, req_cnt - r0, WORD_COUNT); end
  endtask
  task test_mid_reset();
    int d0;
    bit ok;
    flush(); put(32'h5); put(32'h6); put(32'h7); put(32'h8);
    TIE_OPQ_Full = 1;
    d0 = done_cnt;
    start_burst(4);
    tick(3);
    checks++; if ({PopReq, PushReq} !== 2'b01 || OPQ !== 32'h5) begin
      errors++; $display("FAIL t6_buffered pop/push=%b opq=%h want 01 5", {PopReq, PushReq}, OPQ); end
    RESET = 1;
    #1;
    checks++; if ({BUSY, DONE, PopReq, PushReq, WORD_COUNT, CHECKSUM, OPQ} !== '0) begin
      errors++; $display("FAIL t6_async busy=%b pop=%b push=%b opq=%h want all 0", BUSY, PopReq, PushReq, OPQ); end
    tick(2);
    RESET = 0;
    TIE_OPQ_Full = 0;
    tick(3);
    checks++; if (done_cnt != d0 || PushReq !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL t6_no_done pulses=%0d push=%b busy=%b want 0 0 0", done_cnt - d0, PushReq, BUSY); end
    flush(); put(32'h9);
    start_burst(1);
    wait_done(ok);
    checks++; if (!ok || WORD_COUNT !== 16'd1 || CHECKSUM !== 32'h9 || cap0[(cap_n-1) % 64] !== 32'h9) begin
      errors++; $display("FAIL t6_restart done=%b wc=%0d cs=%h last=%h want 1 1 9 9",
        ok, WORD_COUNT, CHECKSUM, cap0[(cap_n-1) % 64]); end
    tick(1);
  endtask
  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_mask();
    test_full_stall();
    test_empty_gaps();
    test_len_zero();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
